// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard command controller: FSM states and
// the command/response byte values exchanged with the keyboard.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_TX,
      ST_WAIT_RESP,
      ST_WAIT_BAT,
      ST_ERR
   } state_t;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_SET_LED  = 8'hED;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

   function automatic logic is_kbd_response(input logic [7:0] b);
      return (b == RSP_ACK) || (b == RSP_RESEND) || (b == RSP_BAT_OK) || (b == RSP_BAT_FAIL);
   endfunction

endpackage

// File: rtl/ps2_kbd_fifo.sv
// Scancode FIFO: synchronous write, combinational head, sticky overflow flag.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module ps2_kbd_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_wr,
   input  logic [7:0] i_wr_data,
   input  logic       i_rd,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_overflow;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_push;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = i_rd && !w_empty;
   assign w_push  = i_wr && (!w_full || w_pop);

   // NOTE: storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (i_wr && !w_push) r_overflow <= 1'b1;
      end
   end

   assign o_valid    = !w_empty;
   assign o_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_kbd_cmd_ctrl.sv
// PS/2 keyboard command controller: issues reset (FF) and LED (ED + arg) commands
// with retry/timeout handling, and buffers scancodes. Option: PS2_KBD_AUTO_INIT_EN.
module ps2_kbd_cmd_ctrl
   import ps2_pkg::*;
#(
   parameter logic [19:0] ACK_TIMEOUT = 20'd800000,
   parameter int          MAX_RETRY   = 3,
   parameter int          FIFO_DEPTH  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rst_req,
   input  logic       led_req,
   input  logic [2:0] led_val,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   input  logic       tx_done,
   input  logic       tx_noack,
   input  logic       rx_strobe,
   input  logic [7:0] rx_data,
   output logic       key_valid,
   output logic [7:0] key_data,
   input  logic       key_ready,
   output logic       busy,
   output logic       kbd_err,
   output logic       overflow
);

   localparam int RW = $clog2(MAX_RETRY + 2);

   state_t        r_state;
   state_t        w_next;
   logic          r_rst_pend;
   logic          r_led_pend;
   logic [2:0]    r_led_val;
   logic          r_cmd_rst;
   logic          r_is_arg;
   logic [7:0]    r_tx_byte;
   logic [RW-1:0] r_retry;
   logic [19:0]   r_tmo;
   logic          r_kbd_err;

   logic w_init, w_in_wait, w_rx_resp, w_rx_ack, w_rx_resend, w_rx_bat_ok, w_rx_bat_fail;
   logic w_timeout, w_retry, w_retry_over, w_accept_rst, w_accept_led, w_next_byte, w_fifo_wr;

`ifdef PS2_KBD_AUTO_INIT_EN
   logic r_init;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_init <= 1'b1;
      else        r_init <= 1'b0;
   end
   assign w_init = r_init;
`else
   assign w_init = 1'b0;
`endif

   assign w_in_wait     = (r_state == ST_WAIT_RESP) || (r_state == ST_WAIT_BAT);
   assign w_rx_resp     = rx_strobe && w_in_wait && is_kbd_response(rx_data);
   assign w_rx_ack      = w_rx_resp && (rx_data == RSP_ACK);
   assign w_rx_resend   = w_rx_resp && (rx_data == RSP_RESEND);
   assign w_rx_bat_ok   = w_rx_resp && (rx_data == RSP_BAT_OK);
   assign w_rx_bat_fail = w_rx_resp && (rx_data == RSP_BAT_FAIL);
   assign w_timeout     = (r_tmo == ACK_TIMEOUT);
   assign w_retry_over  = (r_retry == RW'(MAX_RETRY));
   assign w_retry       = ((r_state == ST_WAIT_TX) && tx_noack && !tx_done) ||
                          ((r_state == ST_WAIT_RESP) && !w_rx_ack && (w_rx_resend || w_timeout));
   assign w_accept_rst  = (r_state == ST_IDLE) && r_rst_pend;
   assign w_accept_led  = (r_state == ST_IDLE) && !r_rst_pend && r_led_pend;
   assign w_next_byte   = (r_state == ST_WAIT_RESP) && w_rx_ack && !r_cmd_rst && !r_is_arg;
   assign w_fifo_wr     = rx_strobe && !w_rx_resp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: default assignment first so every path drives w_next and no latch is inferred.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:      if (r_rst_pend || r_led_pend) w_next = ST_SEND;
         ST_SEND:      if (tx_ready) w_next = ST_WAIT_TX;
         ST_WAIT_TX: begin
            if (tx_done)      w_next = ST_WAIT_RESP;
            else if (w_retry) w_next = w_retry_over ? ST_ERR : ST_SEND;
         end
         ST_WAIT_RESP: begin
            if (w_rx_ack) begin
               if (r_cmd_rst)     w_next = ST_WAIT_BAT;
               else if (r_is_arg) w_next = ST_IDLE;
               else               w_next = ST_SEND;
            end else if (w_retry) begin
               w_next = w_retry_over ? ST_ERR : ST_SEND;
            end
         end
         ST_WAIT_BAT: begin
            if (w_rx_bat_ok)                     w_next = ST_IDLE;
            else if (w_rx_bat_fail || w_timeout) w_next = ST_ERR;
         end
         ST_ERR:       w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_valid = (r_state == ST_SEND);
      busy     = (r_state != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rst_pend <= 1'b0;
         r_led_pend <= 1'b0;
         r_led_val  <= 3'b000;
         r_cmd_rst  <= 1'b0;
         r_is_arg   <= 1'b0;
         r_tx_byte  <= 8'h00;
         r_retry    <= '0;
         r_tmo      <= '0;
         r_kbd_err  <= 1'b0;
      end else begin
         r_rst_pend <= rst_req || w_init || (r_rst_pend && !w_accept_rst);
         r_led_pend <= led_req || w_init || (r_led_pend && !w_accept_led);
         if (led_req)     r_led_val <= led_val;
         else if (w_init) r_led_val <= 3'b000;

         if (w_accept_rst) begin
            r_tx_byte <= CMD_RESET;
            r_cmd_rst <= 1'b1;
            r_is_arg  <= 1'b0;
         end else if (w_accept_led) begin
            r_tx_byte <= CMD_SET_LED;
            r_cmd_rst <= 1'b0;
            r_is_arg  <= 1'b0;
         end else if (w_next_byte) begin
            r_tx_byte <= {5'b00000, r_led_val};
            r_is_arg  <= 1'b1;
         end

         if (w_accept_rst || w_accept_led || w_next_byte) r_retry <= '0;
         else if (w_retry && !w_retry_over)               r_retry <= r_retry + RW'(1);

         // Restarts on every state change, so each wait state begins counting from zero.
         if (w_next != r_state) r_tmo <= '0;
         else if (!w_timeout)   r_tmo <= r_tmo + 20'd1;

         if (w_next == ST_ERR)                           r_kbd_err <= 1'b1;
         else if ((r_state == ST_WAIT_BAT) && w_rx_bat_ok) r_kbd_err <= 1'b0;
      end
   end

   assign tx_data = r_tx_byte;
   assign kbd_err = r_kbd_err;

   ps2_kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_wr       (w_fifo_wr),
      .i_wr_data  (rx_data),
      .i_rd       (key_ready),
      .o_valid    (key_valid),
      .o_data     (key_data),
      .o_overflow (overflow)
   );

endmodule

// File: tb/tb_ps2_kbd_cmd_ctrl.sv
// Self-checking bench for ps2_kbd_cmd_ctrl: command sequences driven by a keyboard
// responder, an LED vector table, and a randomized FIFO run against a queue model.
module tb_ps2_kbd_cmd_ctrl;
   import ps2_pkg::*;

   localparam logic [19:0] TMO     = 20'd40;
   localparam int          RETRIES = 3;
   localparam int          DEPTH   = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rst_req = 1'b0, led_req = 1'b0;
   logic [2:0] led_val = 3'b000;
   logic       tx_valid, tx_ready = 1'b0, tx_done = 1'b0, tx_noack = 1'b0;
   logic [7:0] tx_data;
   logic       rx_strobe = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       key_valid, key_ready = 1'b0;
   logic [7:0] key_data;
   logic       busy, kbd_err, overflow;

   always #5 clk = ~clk;

   ps2_kbd_cmd_ctrl #(.ACK_TIMEOUT(TMO), .MAX_RETRY(RETRIES), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .rst_req(rst_req), .led_req(led_req), .led_val(led_val),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done),
      .tx_noack(tx_noack), .rx_strobe(rx_strobe), .rx_data(rx_data), .key_valid(key_valid),
      .key_data(key_data), .key_ready(key_ready), .busy(busy), .kbd_err(kbd_err),
      .overflow(overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] tx_log[$];

   always @(posedge clk) if (reset && tx_valid && tx_ready) tx_log.push_back(tx_data);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      rx_strobe = 1'b1;
      rx_data   = b;
      tick();
      rx_strobe = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_tx(input string nm);
      int w = 0;
      while (!tx_valid && w < 100) begin
         tick();
         w++;
      end
      if (!tx_valid) check(nm, tx_valid, 1);
   endtask

   // Keyboard responder for one transmitted byte: hand-off, line ack, then reply.
   task automatic do_byte(input string nm, input logic [7:0] resp);
      wait_tx(nm);
      if (!tx_valid) return;
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      pulse_rx(resp);
   endtask

   function automatic logic [7:0] log_at(input int i);
      return (i >= 0 && i < tx_log.size()) ? tx_log[i] : 8'hxx;
   endfunction

   typedef struct {
      logic [2:0] val;
      int         n_fe;
      logic       exp_err;
      int         exp_count;
   } led_vec_t;

   led_vec_t vecs[4];

   initial begin
      logic [7:0] mq[$];
      logic       m_ovf;
      int         k;

      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      logic [7:0] mq[$];
      logic       m_ovf;
      int         k, sz;
      logic       pop;
      logic       saw_tx;

      vecs[0] = '{3'b101, 0, 1'b0, 2};
      vecs[1] = '{3'b010, 3, 1'b0, 5};
      vecs[2] = '{3'b001, 1, 1'b0, 3};
      vecs[3] = '{3'b111, 4, 1'b1, 4};

      do_reset();
      repeat (20) tick();
      check("reset tx_valid", tx_valid, 0);
      check("reset tx_data", tx_data, 8'h00);
      check("reset key_valid", key_valid, 0);
      check("reset key_data", key_data, 8'h00);
      check("reset busy", busy, 0);
      check("reset kbd_err", kbd_err, 0);
      check("reset overflow", overflow, 0);

      // LED command table: FE retries, then ack for command and argument.
      for (int i = 0; i < 4; i++) begin
         tx_log.delete();
         led_val = vecs[i].val;
         led_req = 1'b1;
         tick();
         led_req = 1'b0;
         led_val = 3'b000;
         for (int j = 0; j < vecs[i].n_fe; j++) do_byte("led resend", RSP_RESEND);
         if (!vecs[i].exp_err) begin
            do_byte("led cmd ack", RSP_ACK);
            do_byte("led arg ack", RSP_ACK);
         end
         repeat (10) tick();
         check("led busy", busy, 0);
         check("led kbd_err", kbd_err, vecs[i].exp_err);
         check("led tx count", tx_log.size(), vecs[i].exp_count);
         check("led first byte", log_at(0), CMD_SET_LED);
         if (!vecs[i].exp_err)
            check("led arg byte", log_at(tx_log.size() - 1), {5'b00000, vecs[i].val});
         check("led no fifo write", key_valid, 0);
      end

      // Reset and LED requested together: FF first, then ED with the led_req-cycle value.
      tx_log.delete();
      led_val = 3'b110;
      rst_req = 1'b1;
      led_req = 1'b1;
      tick();
      rst_req = 1'b0;
      led_req = 1'b0;
      led_val = 3'b001;
      do_byte("sim FF", RSP_ACK);
      check("sim state wait_bat", dut.r_state, ST_WAIT_BAT);
      check("sim busy in bat", busy, 1);
      pulse_rx(RSP_BAT_OK);
      check("sim kbd_err cleared", kbd_err, 0);
      do_byte("sim ED", RSP_ACK);
      do_byte("sim arg", RSP_ACK);
      repeat (5) tick();
      check("sim tx count", tx_log.size(), 3);
      check("sim byte0", log_at(0), CMD_RESET);
      check("sim byte1", log_at(1), CMD_SET_LED);
      check("sim byte2", log_at(2), 8'h06);
      check("sim busy", busy, 0);
      check("sim fifo empty", key_valid, 0);

      // Timeout in WAIT_RESP with a scancode arriving meanwhile.
      tx_log.delete();
      led_val = 3'b011;
      led_req = 1'b1;
      tick();
      led_req = 1'b0;
      wait_tx("tmo first send");
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      k = 0;
      repeat (3) begin tick(); k++; end
      pulse_rx(8'h1C);
      k++;
      while (!tx_valid && k < 200) begin tick(); k++; end
      check("tmo resend delay", k, TMO + 1);
      check("tmo resend byte", tx_data, CMD_SET_LED);
      check("tmo fifo valid", key_valid, 1);
      check("tmo fifo data", key_data, 8'h1C);
      tx_ready = 1'b1;
      key_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      key_ready = 1'b0;
      check("tmo fifo popped", key_valid, 0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      pulse_rx(RSP_ACK);
      do_byte("tmo arg", RSP_ACK);
      repeat (3) tick();
      check("tmo tx count", tx_log.size(), 3);
      check("tmo arg byte", log_at(2), 8'h03);
      check("tmo kbd_err", kbd_err, 0);

      // tx_noack counts as a retry.
      tx_log.delete();
      led_val = 3'b100;
      led_req = 1'b1;
      tick();
      led_req = 1'b0;
      wait_tx("noack send");
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      tx_noack = 1'b1;
      tick();
      tx_noack = 1'b0;
      do_byte("noack resend", RSP_ACK);
      do_byte("noack arg", RSP_ACK);
      repeat (3) tick();
      check("noack tx count", tx_log.size(), 3);
      check("noack resend byte", log_at(1), CMD_SET_LED);

      // BAT failure sets kbd_err.
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      do_byte("bat FF", RSP_ACK);
      pulse_rx(RSP_BAT_FAIL);
      tick();
      check("bat fail kbd_err", kbd_err, 1);
      check("bat fail busy", busy, 0);

      // Reset mid-command abandons it.
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      wait_tx("midreset send");
      reset = 1'b0;
      #1;
      check("midreset tx_valid", tx_valid, 0);
      check("midreset kbd_err", kbd_err, 0);
      tick();
      reset = 1'b1;
      saw_tx = 1'b0;
      repeat (20) begin tick(); saw_tx |= tx_valid; end
      check("midreset no tx", saw_tx, 0);
      check("midreset busy", busy, 0);

      // Randomized FIFO traffic in IDLE against a queue model.
      m_ovf = 1'b0;
      for (int c = 0; c < 300; c++) begin
         rx_strobe = (($urandom % 100) < 55);
         rx_data   = 8'($urandom);
         key_ready = (($urandom % 100) < 40);
         sz  = mq.size();
         pop = key_ready && (sz > 0);
         if (pop) void'(mq.pop_front());
         if (rx_strobe) begin
            if (sz < DEPTH || pop) mq.push_back(rx_data);
            else m_ovf = 1'b1;
         end
         tick();
         check("rand key_valid", key_valid, mq.size() > 0);
         check("rand key_data", key_data, (mq.size() > 0) ? mq[0] : 8'h00);
         check("rand overflow", overflow, m_ovf);
      end
      rx_strobe = 1'b0;
      key_ready = 1'b0;

      // 17 writes with no pops: 16 kept, overflow set.
      do_reset();
      check("fill reset overflow", overflow, 0);
      rx_strobe = 1'b1;
      rx_data = 8'h1C;
      repeat (17) tick();
      rx_strobe = 1'b0;
      check("fill overflow", overflow, 1);
      k = 0;
      key_ready = 1'b1;
      while (key_valid && k < 40) begin tick(); k++; end
      key_ready = 1'b0;
      check("fill stored", k, DEPTH);

      // 17th write with a simultaneous pop is accepted.
      do_reset();
      rx_strobe = 1'b1;
      rx_data = 8'h1C;
      repeat (16) tick();
      key_ready = 1'b1;
      tick();
      rx_strobe = 1'b0;
      key_ready = 1'b0;
      check("pushpop overflow", overflow, 0);
      k = 0;
      key_ready = 1'b1;
      while (key_valid && k < 40) begin tick(); k++; end
      key_ready = 1'b0;
      check("pushpop stored", k, DEPTH);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_cmd_ctrl.md
PS2_KBD_CMD_CTRL -- requirements
Module: ps2_kbd_cmd_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 20'd800000, SHALL give the number of clk cycles allowed for any keyboard response (about 10 ms at 80 MHz).
REQ-002 Parameter MAX_RETRY, default 3, SHALL give the number of resends allowed per byte after an FE response or a timeout.
REQ-003 Parameter FIFO_DEPTH, default 16 (power of two), SHALL give the scancode buffer depth.
REQ-004 clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; all state SHALL clear when reset=0.
REQ-006 rst_req  in  1  one-cycle pulse requesting a keyboard reset (command FF).
REQ-007 led_req  in  1  one-cycle pulse requesting an LED update (ED, then the argument).
REQ-008 led_val  in  3  {caps,num,scroll}; SHALL be sampled on the cycle led_req=1.
REQ-009 tx_valid  out  1, tx_data  out  8, tx_ready  in  1  byte hand-off to the PS/2 transmit engine; the transfer SHALL occur on the cycle tx_valid&tx_ready=1.
REQ-010 tx_done  in  1, tx_noack  in  1  one-cycle pulses from the transmit engine: keyboard line-ack received, or no line-ack.
REQ-011 rx_strobe  in  1, rx_data  in  8  raw byte received from the keyboard.
REQ-012 key_valid  out  1, key_data  out  8, key_ready  in  1  scancode FIFO read port; the FIFO SHALL pop when key_valid&key_ready=1.
REQ-013 busy  out  1, kbd_err  out  1, overflow  out  1  status outputs.

Function
REQ-014 The FSM SHALL have the states IDLE, SEND, WAIT_TX, WAIT_RESP, WAIT_BAT and ERR.
REQ-015 rst_req and led_req SHALL each set a pending flag; each flag SHALL clear when its command is accepted from IDLE; a repeated led_req SHALL overwrite the latched led_val.
REQ-016 In IDLE, a pending reset SHALL take priority over a pending LED update; an LED update pending at the same time SHALL be serviced next.
REQ-017 SEND SHALL drive tx_valid=1 with the current byte until tx_ready=1, then go to WAIT_TX; WAIT_TX SHALL go to WAIT_RESP on tx_done and treat tx_noack as a retry event.
REQ-018 WAIT_RESP on rx FA: for ED, the next byte SHALL be {5'b0,led_val}; for the LED argument, the FSM SHALL return to IDLE; for FF, the FSM SHALL go to WAIT_BAT.
REQ-019 A retry event (rx FE, tx_noack, or timeout) SHALL resend the same byte; once the retry count exceeds MAX_RETRY, the FSM SHALL go to ERR.
REQ-020 WAIT_BAT on rx AA SHALL clear kbd_err and return to IDLE; rx FC or a timeout SHALL go to ERR.
REQ-021 ERR SHALL set kbd_err=1, drop the current command and return to IDLE after one cycle; only a completed FF/AA sequence SHALL clear kbd_err.
REQ-022 The timeout counter SHALL clear on entry to WAIT_RESP or WAIT_BAT and saturate at ACK_TIMEOUT; the retry counter SHALL clear on each new byte.
REQ-023 Bytes FA, FE, AA and FC received in WAIT_RESP or WAIT_BAT SHALL be consumed; every other rx byte, and every byte received in any other state, SHALL be written to the FIFO.
REQ-024 FIFO full with a write: the byte SHALL be dropped and overflow set sticky until reset; a simultaneous push and pop on a full FIFO SHALL be accepted.
REQ-025 key_data SHALL be the head entry, with zero read latency.
REQ-026 busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 Reset values SHALL be: state IDLE, tx_valid=0, tx_data=8'h00, key_valid=0, key_data=8'h00, busy=0, kbd_err=0, overflow=0, FIFO empty, pending flags and counters zero.
REQ-028 Reset asserted mid-command SHALL abandon the command with no further tx_valid.

Configuration
REQ-029 With PS2_KBD_AUTO_INIT_EN defined, both pending flags SHALL set on the first cycle after reset release, with led_val=3'b000, so FF then ED 00 issue automatically.
REQ-030 Without PS2_KBD_AUTO_INIT_EN, the controller SHALL stay in IDLE until rst_req or led_req.

Structure
REQ-031 The shared package ps2_pkg SHALL hold the FSM state encodings and the byte constants FF, ED, FA, FE, AA and FC.
REQ-032 The FIFO SHALL be the sub-module ps2_kbd_fifo (parameter DEPTH, synchronous write, combinational head).

Verification
REQ-033 rst_req; tx_ready=1; tx_done; rx AA after FA -> tx_data FF, the FSM in WAIT_BAT, back to IDLE, kbd_err=0, FIFO empty.
REQ-034 led_req with led_val=3'b101; FA twice -> tx sequence ED then 05, busy returns to 0, no FIFO writes.
REQ-035 led_req; rx FE three times then FA -> ED sent four times, argument sent, no kbd_err; with four FE responses, kbd_err=1 and no argument sent.
REQ-036 rst_req and led_req on the same cycle -> FF is serviced first, then ED 0x; led_val is taken from the led_req cycle.
REQ-037 17 rx bytes 1C with no pops -> 16 stored, overflow=1; a pop on the 17th cycle -> that byte is accepted instead.
REQ-038 WAIT_RESP with no response -> after ACK_TIMEOUT cycles a resend of the same byte; rx 1C arriving during WAIT_RESP -> placed in the FIFO.
